// File: rtl/execute_muldiv.sv
// rtl/execute_muldiv.sv - iterative RV64M multiply/divide unit for the execute stage
// Optional FAST_MUL_EN: single-cycle combinational multiply, divides stay iterative.
module execute_muldiv #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        opReg;
    logic              wordReg, signDiff, negRem, special;
    logic [2*XLEN-1:0] prodReg, mcandReg;
    logic [XLEN-1:0]   mplierReg, quotReg, remReg, divisorReg, resultReg;
    logic [TAG_W-1:0]  tagReg;

    function automatic logic [XLEN-1:0] extend32(input logic [31:0] v, input logic s);
        logic [XLEN-1:0] r;
        r = '0;
        r[31:0] = v;
        for (int i = 32; i < XLEN; i++) r[i] = s & v[31];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] fixWord(input logic [XLEN-1:0] v, input logic w);
        return w ? extend32(v[31:0], 1'b1) : v;
    endfunction

    // High-half ops combined with word are not legal encodings; they fall back to MUL.
    function automatic logic [XLEN-1:0] mulSel(input logic [2*XLEN-1:0] p, input logic neg,
                                              input logic [2:0] op, input logic w);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        if (w) return extend32(s[31:0], 1'b1);
        else if (op[1:0] == 2'd0) return s[XLEN-1:0];
        else return s[2*XLEN-1:XLEN];
    endfunction

    // Operand preparation at accept
    logic            wordMul, opSignedA, opSignedB, negA, negB, divZero, overflow;
    logic [XLEN-1:0] extA, extB, absA, absB, minVal, specialRes;

    assign wordMul   = in_word & ~in_op[2];
    assign opSignedA = (in_op == 3'd1 || in_op == 3'd2 || in_op == 3'd4 || in_op == 3'd6) && !wordMul;
    assign opSignedB = (in_op == 3'd1 || in_op == 3'd4 || in_op == 3'd6) && !wordMul;
    assign extA      = in_word ? extend32(in_src1[31:0], opSignedA) : in_src1;
    assign extB      = in_word ? extend32(in_src2[31:0], opSignedB) : in_src2;
    assign negA      = opSignedA & extA[XLEN-1];
    assign negB      = opSignedB & extB[XLEN-1];
    assign absA      = negA ? -extA : extA;
    assign absB      = negB ? -extB : extB;
    assign minVal    = in_word ? extend32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    assign divZero   = (extB == '0);
    assign overflow  = in_op[2] & ~in_op[0] & (extA == minVal) & (extB == '1);
    assign specialRes = divZero ? (in_op[1] ? extA : '1) : (in_op[1] ? '0 : extA);

    // One iteration of shift-add multiply and restoring divide
    logic [2*XLEN-1:0] prodNext;
    logic [XLEN:0]     remShift, diff;
    logic              geq;
    logic [XLEN-1:0]   remNext, quotNext, divRes;

    assign prodNext = mplierReg[0] ? prodReg + mcandReg : prodReg;
    assign remShift = {remReg, quotReg[XLEN-1]};
    assign diff     = remShift - {1'b0, divisorReg};
    assign geq      = ~diff[XLEN];
    assign remNext  = geq ? diff[XLEN-1:0] : remShift[XLEN-1:0];
    assign quotNext = {quotReg[XLEN-2:0], geq};
    assign divRes   = fixWord(opReg[1] ? (negRem ? -remNext : remNext)
                                       : (signDiff ? -quotNext : quotNext), wordReg);

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fastProd;
    assign fastProd = {{XLEN{1'b0}}, absA} * {{XLEN{1'b0}}, absB};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            opReg      <= '0;
            wordReg    <= 1'b0;
            signDiff   <= 1'b0;
            negRem     <= 1'b0;
            special    <= 1'b0;
            prodReg    <= '0;
            mcandReg   <= '0;
            mplierReg  <= '0;
            quotReg    <= '0;
            remReg     <= '0;
            divisorReg <= '0;
            resultReg  <= '0;
            tagReg     <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    opReg      <= in_op;
                    wordReg    <= in_word;
                    tagReg     <= in_tag;
                    signDiff   <= negA ^ negB;
                    negRem     <= negA;
                    prodReg    <= '0;
                    mcandReg   <= {{XLEN{1'b0}}, absA};
                    mplierReg  <= absB;
                    remReg     <= '0;
                    // Word dividends are left-aligned so 32 shifts clear them out
                    quotReg    <= in_word ? (absA << (XLEN - 32)) : absA;
                    divisorReg <= absB;
                    special    <= in_op[2] & (divZero | overflow);
                    resultReg  <= fixWord(specialRes, in_word);
                    if (in_op[2] & (divZero | overflow)) cnt <= '0;
                    else cnt <= in_word ? CW'(31) : CW'(XLEN - 1);
                    state      <= CALC;
`ifdef FAST_MUL_EN
                    if (!in_op[2]) begin
                        resultReg <= mulSel(fastProd, negA ^ negB, in_op, in_word);
                        state     <= DONE;
                    end
`endif
                end
                CALC: begin
                    prodReg   <= prodNext;
                    mcandReg  <= mcandReg << 1;
                    mplierReg <= mplierReg >> 1;
                    remReg    <= remNext;
                    quotReg   <= quotNext;
                    cnt       <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= DONE;
                        if (!special)
                            resultReg <= opReg[2] ? divRes : mulSel(prodNext, signDiff, opReg, wordReg);
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign out_valid  = (state == DONE);
    assign out_result = resultReg;
    assign out_tag    = tagReg;
endmodule
